fnd_page_scheduler: RTL and testbench

FND_PAGE_SCHEDULER -- requirements
Module: fnd_page_scheduler

---
 rtl/fnd_sched_pkg.sv | 16 +
 rtl/fnd_ms_tick.sv | 30 +++
 rtl/fnd_page_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_fnd_page_scheduler.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fnd_sched_pkg.sv
// Shared definitions for the FND page scheduler.
//   state_t  : scheduler FSM states (IDLE, SHOW_LO, SHOW_HI)
//   OWN_*    : codes driven on the owner output
package fnd_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHOW_LO = 2'd1,
    ST_SHOW_HI = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_0    = 2'b01;
  localparam logic [1:0] OWN_1    = 2'b10;

endpackage

// File: rtl/fnd_ms_tick.sv
// Free-running prescaler producing a one-cycle tick every TICK_CYCLES clocks.
//   clk   : system clock
//   reset : synchronous active-high reset (counter to 0)
//   tick  : high for one cycle while the counter sits at TICK_CYCLES-1
module fnd_ms_tick #(
  parameter int unsigned TICK_CYCLES = 100_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/fnd_page_scheduler.sv
// Time-shares a 4-digit FND display between two requesters. Each 32-bit word
// is shown as a lower-half page then an upper-half page, PAGE_MS ticks each.
//   clk, reset    : clock, synchronous active-high reset
//   req0/req1     : one-cycle request pulses; data0/data1 sampled with them
//   ack0/ack1     : one-cycle pulse the cycle after a request is captured
//   disp_data     : word presented to the FND controller
//   show_hi       : 1 = upper 16 bits, 0 = lower 16 bits
//   owner         : OWN_NONE / OWN_0 / OWN_1
module fnd_page_scheduler
  import fnd_sched_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 100_000,
  parameter int unsigned PAGE_MS     = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] disp_data,
  output logic        show_hi,
  output logic [1:0]  owner
);

  localparam int unsigned PW = (PAGE_MS > 1) ? $clog2(PAGE_MS) : 1;
  localparam logic [PW-1:0] PG_LAST = PW'(PAGE_MS - 1);

  logic tick;

  fnd_ms_tick #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  state_t        state, state_n;
  logic          pend0, pend1, pend0_n, pend1_n;
  logic [31:0]   word0, word1, word0_n, word1_n;
  logic [31:0]   disp_n;
  logic [1:0]    owner_n;
  logic          rr, rr_n;          // requester that wins a tie
  logic [PW-1:0] pg, pg_n;
  logic          has0, has1, pick0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend0     <= 1'b0;
      pend1     <= 1'b0;
      word0     <= '0;
      word1     <= '0;
      disp_data <= '0;
      owner     <= OWN_NONE;
      rr        <= 1'b0;
      pg        <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
    end else begin
      pend0     <= pend0_n;
      pend1     <= pend1_n;
      word0     <= word0_n;
      word1     <= word1_n;
      disp_data <= disp_n;
      owner     <= owner_n;
      rr        <= rr_n;
      pg        <= pg_n;
      ack0      <= req0;
      ack1      <= req1;
    end
  end

  assign show_hi = (state == ST_SHOW_HI);

  always_comb begin
    state_n = state;
    pend0_n = pend0 | req0;
    pend1_n = pend1 | req1;
    word0_n = req0 ? data0 : word0;
    word1_n = req1 ? data1 : word1;
    disp_n  = disp_data;
    owner_n = owner;
    rr_n    = rr;
    pg_n    = pg;
    has0    = 1'b0;
    has1    = 1'b0;
    pick0   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // A request sampled on this edge is granted directly, bypassing the
        // pending buffer.
        has0  = pend0 | req0;
        has1  = pend1 | req1;
        pick0 = has0 && (!has1 || (rr == 1'b0));
        if (has0 || has1) begin
          if (pick0) begin
            disp_n  = req0 ? data0 : word0;
            owner_n = OWN_0;
            pend0_n = 1'b0;
            rr_n    = 1'b1;
          end else begin
            disp_n  = req1 ? data1 : word1;
            owner_n = OWN_1;
            pend1_n = 1'b0;
            rr_n    = 1'b0;
          end
          pg_n    = '0;
          state_n = ST_SHOW_LO;
        end
      end

      ST_SHOW_LO: begin
        if (tick) begin
          if (pg == PG_LAST) begin
            pg_n    = '0;
            state_n = ST_SHOW_HI;
          end else begin
            pg_n = pg + 1'b1;
          end
        end
      end

      ST_SHOW_HI: begin
        if (tick) begin
          if (pg == PG_LAST) begin
            // Page boundary: only already-registered pending words compete;
            // a req on this same edge lands in the buffer for the next one.
            // The other requester always wins here, which is the round-robin
            // rule since the current owner was the last one granted.
            if (owner == OWN_0) begin
              pick0 = !pend1 && pend0;
              if (pend1 || pend0) begin
                if (pick0) begin
                  disp_n  = word0;
                  pend0_n = req0;
                end else begin
                  disp_n  = word1;
                  owner_n = OWN_1;
                  pend1_n = req1;
                end
              end
            end else begin
              pick0 = pend0;
              if (pend0 || pend1) begin
                if (pick0) begin
                  disp_n  = word0;
                  owner_n = OWN_0;
                  pend0_n = req0;
                end else begin
                  disp_n  = word1;
                  pend1_n = req1;
                end
              end
            end
            rr_n    = (owner_n == OWN_0) ? 1'b1 : 1'b0;
            pg_n    = '0;
            state_n = ST_SHOW_LO;
          end else begin
            pg_n = pg + 1'b1;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fnd_page_scheduler.sv
// Directed bench for fnd_page_scheduler with TICK_CYCLES=4, PAGE_MS=3.
// Edge E0 is the first rising clock edge; reset is held over E0..E2, so tick
// edges fall on E6, E10, E14, ... and a page spans 3 ticks (12 cycles).
module tb_fnd_page_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] data0 = '0, data1 = '0;
  logic        ack0, ack1, show_hi;
  logic [31:0] disp_data;
  logic [1:0]  owner;

  int errors = 0;
  int checks = 0;
  int e = -1;

  fnd_page_scheduler #(.TICK_CYCLES(4), .PAGE_MS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .ack0      (ack0),
    .ack1      (ack1),
    .disp_data (disp_data),
    .show_hi   (show_hi),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    e = e + 1;
    #1;
  endtask

  // Advance until just after edge n.
  task automatic go(input int n);
    while (e < n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic chk_all(input string tag, input logic a0, input logic a1,
                         input logic [1:0] own, input logic [31:0] dd, input logic hi);
    chk({tag, ".ack0"}, {31'd0, ack0}, {31'd0, a0});
    chk({tag, ".ack1"}, {31'd0, ack1}, {31'd0, a1});
    chk({tag, ".owner"}, {30'd0, owner}, {30'd0, own});
    chk({tag, ".disp"}, disp_data, dd);
    chk({tag, ".show_hi"}, {31'd0, show_hi}, {31'd0, hi});
  endtask

  initial begin
    // Reset state
    go(2);
    chk_all("rst", 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    reset = 1'b0;

    // First grant: req0 sampled at E10
    go(9);
    req0 = 1'b1; data0 = 32'h1234_ABCD;
    go(10);
    req0 = 1'b0; data0 = '0;
    chk_all("grant0", 1'b1, 1'b0, 2'b01, 32'h1234_ABCD, 1'b0);
    go(11);
    chk("ack0_drop", {31'd0, ack0}, 32'd0);

    // req1 during owner-0 page, sampled at E15
    go(14);
    req1 = 1'b1; data1 = 32'h0000_5678;
    go(15);
    req1 = 1'b0; data1 = '0;
    chk_all("req1_ack", 1'b0, 1'b1, 2'b01, 32'h1234_ABCD, 1'b0);

    go(21);
    chk("lo_end", {31'd0, show_hi}, 32'd0);
    go(22);
    chk_all("hi_start", 1'b0, 1'b0, 2'b01, 32'h1234_ABCD, 1'b1);
    go(33);
    chk_all("hi_end", 1'b0, 1'b0, 2'b01, 32'h1234_ABCD, 1'b1);
    go(34);
    chk_all("grant1", 1'b0, 1'b0, 2'b10, 32'h0000_5678, 1'b0);

    // Three req0 overwrites during owner-1 page: E36, E38, E40
    for (int unsigned k = 1; k <= 3; k++) begin
      go(35 + 2 * int'(k) - 2);
      req0 = 1'b1; data0 = k;
      step();
      req0 = 1'b0; data0 = '0;
      chk($sformatf("ow_ack%0d", k), {31'd0, ack0}, 32'd1);
      step();
      chk($sformatf("ow_ackoff%0d", k), {31'd0, ack0}, 32'd0);
    end

    // Decision at E58, plus a req1 landing on that same edge
    go(57);
    chk_all("pre_dec2", 1'b0, 1'b0, 2'b10, 32'h0000_5678, 1'b1);
    req1 = 1'b1; data1 = 32'h9ABC_0000;
    go(58);
    req1 = 1'b0; data1 = '0;
    chk_all("grant0_latest", 1'b0, 1'b1, 2'b01, 32'h0000_0003, 1'b0);

    // Same-edge req1 is served at the following decision (E82)
    go(81);
    chk_all("pre_dec3", 1'b0, 1'b0, 2'b01, 32'h0000_0003, 1'b1);
    go(82);
    chk_all("grant1_keep", 1'b0, 1'b0, 2'b10, 32'h9ABC_0000, 1'b0);

    // Nobody pending: current word repeats at E106
    go(105);
    chk("pre_rep.hi", {31'd0, show_hi}, 32'd1);
    go(106);
    chk_all("repeat", 1'b0, 1'b0, 2'b10, 32'h9ABC_0000, 1'b0);

    // Reset mid-SHOW_HI (HI from E118), req0 during reset ignored
    go(118);
    chk("mid_hi", {31'd0, show_hi}, 32'd1);
    go(120);
    reset = 1'b1; req0 = 1'b1; data0 = 32'hDEAD_BEEF;
    go(121);
    req0 = 1'b0; data0 = '0;
    chk_all("rst_mid", 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    go(122);
    reset = 1'b0;
    go(125);
    chk_all("post_rst", 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);

    // Simultaneous requests from IDLE after reset, sampled at E126
    req0 = 1'b1; data0 = 32'hAAAA_0001;
    req1 = 1'b1; data1 = 32'hBBBB_0002;
    go(126);
    req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    chk_all("both", 1'b1, 1'b1, 2'b01, 32'hAAAA_0001, 1'b0);
    go(138);
    chk_all("both_hi", 1'b0, 1'b0, 2'b01, 32'hAAAA_0001, 1'b1);
    go(149);
    chk("both_pre.owner", {30'd0, owner}, 32'd1);
    go(150);
    chk_all("both_next", 1'b0, 1'b0, 2'b10, 32'hBBBB_0002, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
